// File: rtl/decode_pkg.sv
// Shared types and widths for the decode dispatch arbiter: ID/payload widths, payload field
// offsets, lane identifiers and the wrap-safe age compare.
package decode_pkg;

  localparam int unsigned MAJ_ID_WIDTH  = 64;
  localparam int unsigned PAYLOAD_WIDTH = 244;
  localparam int unsigned ENTRY_WIDTH   = MAJ_ID_WIDTH + PAYLOAD_WIDTH;

  // Payload field widths, LSB-first layout (body occupies the low bits).
  localparam int unsigned BodyW    = 121;
  localparam int unsigned IsRegW   = 1;
  localparam int unsigned RwW      = 1;
  localparam int unsigned TidW     = 16;
  localparam int unsigned PidW     = 16;
  localparam int unsigned Is64W    = 1;
  localparam int unsigned MinIdW   = 8;
  localparam int unsigned UnitW    = 4;
  localparam int unsigned AddressW = 64;
  localparam int unsigned OpcodeW  = 8;
  localparam int unsigned FormatW  = 4;

  localparam int unsigned BodyLsb    = 0;
  localparam int unsigned IsRegLsb   = BodyLsb + BodyW;
  localparam int unsigned RwLsb      = IsRegLsb + IsRegW;
  localparam int unsigned TidLsb     = RwLsb + RwW;
  localparam int unsigned PidLsb     = TidLsb + TidW;
  localparam int unsigned Is64Lsb    = PidLsb + PidW;
  localparam int unsigned MinIdLsb   = Is64Lsb + Is64W;
  localparam int unsigned UnitLsb    = MinIdLsb + MinIdW;
  localparam int unsigned AddressLsb = UnitLsb + UnitW;
  localparam int unsigned OpcodeLsb  = AddressLsb + AddressW;
  localparam int unsigned FormatLsb  = OpcodeLsb + OpcodeW;

  typedef enum logic {
    Lane0 = 1'b0,
    Lane1 = 1'b1
  } lane_id_e;

  // a is older than b when (a - b) is negative in MAJ_ID_WIDTH-bit two's complement.
  function automatic logic maj_id_older(input logic [MAJ_ID_WIDTH-1:0] a,
                                        input logic [MAJ_ID_WIDTH-1:0] b);
    logic [MAJ_ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[MAJ_ID_WIDTH-1];
  endfunction

endpackage

// File: rtl/decode_lane_fifo.sv
// Per-lane synchronous FIFO with combinational head read. A push on a full FIFO is taken
// only when the same edge pops.
module decode_lane_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW-1:0]  free_count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign full_o       = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                        (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign free_count_o = PtrW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
  assign head_o       = mem_q[rd_ptr_q[PtrW-2:0]];

  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_ptr_q[PtrW-2:0]] <= data_i;
  end

endmodule

// File: rtl/decode_dispatch_arbiter.sv
// Merges two decode lanes into one valid/ready dispatch port, oldest majID first, with
// per-lane back-pressure and sticky overflow. DECODE_ARB_PERF_EN adds perf counters.
module decode_dispatch_arbiter
  import decode_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned STALL_THRESHOLD = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     lane0_enable_i,
  input  logic [MAJ_ID_WIDTH-1:0]  lane0_majId_i,
  input  logic [PAYLOAD_WIDTH-1:0] lane0_payload_i,
  output logic                     lane0_stall_o,
  output logic                     lane0_overflow_o,
  input  logic                     lane1_enable_i,
  input  logic [MAJ_ID_WIDTH-1:0]  lane1_majId_i,
  input  logic [PAYLOAD_WIDTH-1:0] lane1_payload_i,
  output logic                     lane1_stall_o,
  output logic                     lane1_overflow_o,
`ifdef DECODE_ARB_PERF_EN
  output logic [31:0]              perf_dispatched_o,
  output logic [31:0]              perf_stall_o,
`endif
  output logic                     dispatch_valid_o,
  input  logic                     dispatch_ready_i,
  output logic [MAJ_ID_WIDTH-1:0]  dispatch_majId_o,
  output logic [PAYLOAD_WIDTH-1:0] dispatch_payload_o,
  output logic                     dispatch_lane_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]             push, pop, push_acc, full, empty, drop;
  logic [ENTRY_WIDTH-1:0] wdata [2];
  logic [ENTRY_WIDTH-1:0] head  [2];
  logic [PtrW-1:0]        free  [2];
  logic [PtrW:0]          free_nxt [2];

  logic                     valid_q, valid_d;
  logic [MAJ_ID_WIDTH-1:0]  maj_q, maj_d;
  logic [PAYLOAD_WIDTH-1:0] pay_q, pay_d;
  lane_id_e                 lane_q, lane_d;
  logic [1:0]               stall_q, stall_d;
  logic [1:0]               ovf_q, ovf_d;

  logic                     load, any_head, sel_lane1;
  logic [MAJ_ID_WIDTH-1:0]  head_maj0, head_maj1;
  logic [ENTRY_WIDTH-1:0]   sel_entry;

  assign push     = {lane1_enable_i, lane0_enable_i};
  assign wdata[0] = {lane0_majId_i, lane0_payload_i};
  assign wdata[1] = {lane1_majId_i, lane1_payload_i};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    decode_lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .push_i       (push[g]),
      .data_i       (wdata[g]),
      .pop_i        (pop[g]),
      .head_o       (head[g]),
      .full_o       (full[g]),
      .empty_o      (empty[g]),
      .free_count_o (free[g])
    );
  end

  assign head_maj0 = head[0][ENTRY_WIDTH-1 -: MAJ_ID_WIDTH];
  assign head_maj1 = head[1][ENTRY_WIDTH-1 -: MAJ_ID_WIDTH];

  // Register refills when empty or being consumed; a stalled packet freezes both FIFOs.
  assign load      = ~valid_q | dispatch_ready_i;
  assign any_head  = ~empty[0] | ~empty[1];
  assign sel_lane1 = empty[0] | (~empty[1] & maj_id_older(head_maj1, head_maj0));
  assign sel_entry = sel_lane1 ? head[1] : head[0];
  assign pop[0]    = load & ~empty[0] & ~sel_lane1;
  assign pop[1]    = load & ~empty[1] & sel_lane1;

  always_comb begin
    valid_d = valid_q;
    maj_d   = maj_q;
    pay_d   = pay_q;
    lane_d  = lane_q;
    if (load) begin
      valid_d = any_head;
      if (any_head) begin
        maj_d  = sel_entry[ENTRY_WIDTH-1 -: MAJ_ID_WIDTH];
        pay_d  = sel_entry[PAYLOAD_WIDTH-1:0];
        lane_d = sel_lane1 ? Lane1 : Lane0;
      end
    end
  end

  always_comb begin
    push_acc = '0;
    drop     = '0;
    stall_d  = '0;
    ovf_d    = ovf_q;
    for (int i = 0; i < 2; i++) begin
      push_acc[i] = push[i] & (~full[i] | pop[i]);
      drop[i]     = push[i] & full[i] & ~pop[i];
      free_nxt[i] = {1'b0, free[i]} + {{PtrW{1'b0}}, pop[i]} - {{PtrW{1'b0}}, push_acc[i]};
      stall_d[i]  = (32'(free_nxt[i]) <= STALL_THRESHOLD);
      ovf_d[i]    = ovf_q[i] | drop[i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      maj_q   <= '0;
      pay_q   <= '0;
      lane_q  <= Lane0;
      stall_q <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      maj_q   <= maj_d;
      pay_q   <= pay_d;
      lane_q  <= lane_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dispatch_valid_o   = valid_q;
  assign dispatch_majId_o   = maj_q;
  assign dispatch_payload_o = pay_q;
  assign dispatch_lane_o    = lane_q;
  assign lane0_stall_o      = stall_q[0];
  assign lane1_stall_o      = stall_q[1];
  assign lane0_overflow_o   = ovf_q[0];
  assign lane1_overflow_o   = ovf_q[1];

`ifdef DECODE_ARB_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_disp_d  = perf_disp_q;
    perf_stall_d = perf_stall_q;
    if (valid_q && dispatch_ready_i && (perf_disp_q != '1)) perf_disp_d = perf_disp_q + 32'd1;
    if ((|stall_q) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_disp_q  <= perf_disp_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_dispatched_o = perf_disp_q;
  assign perf_stall_o      = perf_stall_q;
`endif

endmodule
